branch_predictor_table: RTL and testbench

- Parametrised successor to the single 2-bit saturating-counter predictor.
- Holds a table of 2^INDEX_BITS saturating counters of CTR_BITS width, indexed by PC bits, with optional gshare indexing (global history XOR PC).
- Serves one prediction request and one resolved-branch update per cycle, both in the same cycle if needed.
- Keeps saturating update and mispredict statistics for the fetch stage and performance monitor.

---
 rtl/branch_predictor_table_if.sv | 34 +++
 rtl/branch_predictor_table.sv | 121 ++++++++++++
 tb/tb_branch_predictor_table.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_table_if.sv
// Branch predictor table interface.
// Groups the fetch-side prediction request/response and the
// resolution-side update strobe plus the statistics outputs.
//   master : fetch/resolve side (drives request, request_pc, result,
//            result_index, taken; observes predictions and statistics)
//   slave  : the predictor table itself
interface branch_predictor_table_if #(
    parameter int PC_WIDTH   = 32,
    parameter int INDEX_BITS = 4,
    parameter int STAT_BITS  = 16
);
    logic                  request;
    logic [PC_WIDTH-1:0]   request_pc;
    logic                  prediction;
    logic                  prediction_valid;
    logic [INDEX_BITS-1:0] prediction_index;
    logic                  result;
    logic [INDEX_BITS-1:0] result_index;
    logic                  taken;
    logic [STAT_BITS-1:0]  stat_updates;
    logic [STAT_BITS-1:0]  stat_mispredicts;

    modport master (
        output request, request_pc, result, result_index, taken,
        input  prediction, prediction_valid, prediction_index,
        input  stat_updates, stat_mispredicts
    );

    modport slave (
        input  request, request_pc, result, result_index, taken,
        output prediction, prediction_valid, prediction_index,
        output stat_updates, stat_mispredicts
    );
endinterface

// File: rtl/branch_predictor_table.sv
// Branch predictor table: 2^INDEX_BITS saturating counters, indexed by
// PC bits optionally XORed with a non-speculative global history (gshare).
// One registered prediction read and one resolved-branch update per cycle.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bp    : slave side of branch_predictor_table_if
//           (request/request_pc in, prediction/prediction_valid/
//            prediction_index out, result/result_index/taken in,
//            stat_updates/stat_mispredicts out)
module branch_predictor_table #(
    parameter int PC_WIDTH   = 32,
    parameter int INDEX_BITS = 4,
    parameter int CTR_BITS   = 2,
    parameter int HIST_BITS  = 0,
    parameter int CTR_INIT   = 1,
    parameter int STAT_BITS  = 16
) (
    input logic                      clk,
    input logic                      reset,
    branch_predictor_table_if.slave  bp
);
    localparam int                  DEPTH      = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX    = '1;
    localparam logic [CTR_BITS-1:0] CTR_INIT_V = CTR_BITS'(CTR_INIT);

    logic [CTR_BITS-1:0]   counters [DEPTH];
    logic [INDEX_BITS-1:0] pc_index;
    logic [INDEX_BITS-1:0] ghr_ext;
    logic [INDEX_BITS-1:0] idx;
    logic [CTR_BITS-1:0]   old_ctr;
    logic [CTR_BITS-1:0]   new_ctr;
    logic                  mispredict;
    logic                  unused_pc_bits;

    // PC bits outside the index field alias by design.
    assign pc_index       = bp.request_pc[INDEX_BITS+1:2];
    assign unused_pc_bits = ^{bp.request_pc[PC_WIDTH-1:INDEX_BITS+2], bp.request_pc[1:0]};

    // Global history only exists in gshare configurations; it shifts in
    // resolved directions, so it never needs repair after a mispredict.
    generate
        if (HIST_BITS == 0) begin : g_bimodal
            assign ghr_ext = '0;
        end else begin : g_gshare
            logic [HIST_BITS-1:0] ghr;
            if (HIST_BITS == 1) begin : g_hist_one
                always_ff @(posedge clk or posedge reset) begin
                    if (reset)
                        ghr <= '0;
                    else if (bp.result)
                        ghr <= bp.taken;
                end
            end else begin : g_hist_many
                always_ff @(posedge clk or posedge reset) begin
                    if (reset)
                        ghr <= '0;
                    else if (bp.result)
                        ghr <= {ghr[HIST_BITS-2:0], bp.taken};
                end
            end
            assign ghr_ext = INDEX_BITS'(ghr);
        end
    endgenerate

    assign idx = pc_index ^ ghr_ext;

    // Saturating next value of the entry being resolved.
    always_comb begin
        old_ctr = counters[bp.result_index];
        new_ctr = old_ctr;
        if (bp.taken) begin
            if (old_ctr != CTR_MAX)
                new_ctr = old_ctr + 1'b1;
        end else begin
            if (old_ctr != '0)
                new_ctr = old_ctr - 1'b1;
        end
    end

    assign mispredict = old_ctr[CTR_BITS-1] != bp.taken;

    // Counter table; a same-cycle request still sees the old contents
    // because the read below samples before this write lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                counters[i] <= CTR_INIT_V;
        end else if (bp.result) begin
            counters[bp.result_index] <= new_ctr;
        end
    end

    // Registered read port; prediction and index hold between requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bp.prediction       <= 1'b0;
            bp.prediction_valid <= 1'b0;
            bp.prediction_index <= '0;
        end else begin
            bp.prediction_valid <= bp.request;
            if (bp.request) begin
                bp.prediction       <= counters[idx][CTR_BITS-1];
                bp.prediction_index <= idx;
            end
        end
    end

    // Statistics, each saturating independently at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bp.stat_updates     <= '0;
            bp.stat_mispredicts <= '0;
        end else if (bp.result) begin
            if (bp.stat_updates != '1)
                bp.stat_updates <= bp.stat_updates + 1'b1;
            if (mispredict && (bp.stat_mispredicts != '1))
                bp.stat_mispredicts <= bp.stat_mispredicts + 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_predictor_table.sv
// Testbench for branch_predictor_table.
// Two instances: a bimodal table with 16-bit stats (b0) and a gshare
// table with 4 history bits and 2-bit stats (b1) to reach stat saturation.
module tb_branch_predictor_table;
    logic clk = 1'b0;
    logic reset;
    int   assert_count = 0;
    int   fail_count   = 0;

    always #5 clk = ~clk;

    branch_predictor_table_if #(.PC_WIDTH(32), .INDEX_BITS(4), .STAT_BITS(16)) b0 ();
    branch_predictor_table_if #(.PC_WIDTH(32), .INDEX_BITS(4), .STAT_BITS(2))  b1 ();

    branch_predictor_table #(
        .PC_WIDTH(32), .INDEX_BITS(4), .CTR_BITS(2),
        .HIST_BITS(0), .CTR_INIT(1), .STAT_BITS(16)
    ) u_bimodal (
        .clk   (clk),
        .reset (reset),
        .bp    (b0)
    );

    branch_predictor_table #(
        .PC_WIDTH(32), .INDEX_BITS(4), .CTR_BITS(2),
        .HIST_BITS(4), .CTR_INIT(1), .STAT_BITS(2)
    ) u_gshare (
        .clk   (clk),
        .reset (reset),
        .bp    (b1)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus on the bimodal instance, then idle inputs.
    task automatic pulse0(input bit req, input logic [31:0] pc,
                          input bit res, input logic [3:0] ridx, input bit tk);
        b0.request      = req;
        b0.request_pc   = pc;
        b0.result       = res;
        b0.result_index = ridx;
        b0.taken        = tk;
        step();
        b0.request = 1'b0;
        b0.result  = 1'b0;
    endtask

    // One cycle of stimulus on the gshare instance, then idle inputs.
    task automatic pulse1(input bit req, input logic [31:0] pc,
                          input bit res, input logic [3:0] ridx, input bit tk);
        b1.request      = req;
        b1.request_pc   = pc;
        b1.result       = res;
        b1.result_index = ridx;
        b1.taken        = tk;
        step();
        b1.request = 1'b0;
        b1.result  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        assert_count++;
        if (b0.prediction !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL reset_pred: got %b expected 0", b0.prediction);
        end
        assert_count++;
        if (b0.prediction_valid !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL reset_valid: got %b expected 0", b0.prediction_valid);
        end
        assert_count++;
        if (b0.prediction_index !== 4'd0) begin
            fail_count++;
            $display("[TB] FAIL reset_index: got %0d expected 0", b0.prediction_index);
        end
        assert_count++;
        if (b0.stat_updates !== 16'd0 || b0.stat_mispredicts !== 16'd0) begin
            fail_count++;
            $display("[TB] FAIL reset_stats: got %0d/%0d expected 0/0",
                     b0.stat_updates, b0.stat_mispredicts);
        end
        assert_count++;
        if (b1.stat_updates !== 2'd0 || b1.prediction_valid !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL reset_gshare: got stats=%0d valid=%b expected 0/0",
                     b1.stat_updates, b1.prediction_valid);
        end
        reset = 1'b0;
    endtask

    task automatic test_first_request();
        pulse0(1'b1, 32'h40, 1'b0, 4'd0, 1'b0);
        assert_count++;
        if (b0.prediction_valid !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL first_valid: got %b expected 1", b0.prediction_valid);
        end
        assert_count++;
        if (b0.prediction !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL first_pred: got %b expected 0", b0.prediction);
        end
        assert_count++;
        if (b0.prediction_index !== 4'd0) begin
            fail_count++;
            $display("[TB] FAIL first_index: got %0d expected 0", b0.prediction_index);
        end
        step();
        assert_count++;
        if (b0.prediction_valid !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL first_valid_drop: got %b expected 0", b0.prediction_valid);
        end
    endtask

    // Index 0: 1->2->3->3 then 3->2->1->0->0.
    task automatic test_saturation();
        for (int i = 0; i < 3; i++)
            pulse0(1'b0, 32'h0, 1'b1, 4'd0, 1'b1);
        pulse0(1'b1, 32'h40, 1'b0, 4'd0, 1'b0);
        assert_count++;
        if (b0.prediction !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL sat_up_pred: got %b expected 1", b0.prediction);
        end
        assert_count++;
        if (b0.stat_updates !== 16'd3 || b0.stat_mispredicts !== 16'd1) begin
            fail_count++;
            $display("[TB] FAIL sat_up_stats: got %0d/%0d expected 3/1",
                     b0.stat_updates, b0.stat_mispredicts);
        end
        for (int i = 0; i < 4; i++)
            pulse0(1'b0, 32'h0, 1'b1, 4'd0, 1'b0);
        pulse0(1'b1, 32'h40, 1'b0, 4'd0, 1'b0);
        assert_count++;
        if (b0.prediction !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL sat_down_pred: got %b expected 0", b0.prediction);
        end
        assert_count++;
        if (b0.stat_updates !== 16'd7 || b0.stat_mispredicts !== 16'd3) begin
            fail_count++;
            $display("[TB] FAIL sat_down_stats: got %0d/%0d expected 7/3",
                     b0.stat_updates, b0.stat_mispredicts);
        end
        // Counter at 0 must not wrap: one taken brings it to 1, MSB still 0.
        pulse0(1'b0, 32'h0, 1'b1, 4'd0, 1'b1);
        pulse0(1'b1, 32'h40, 1'b0, 4'd0, 1'b0);
        assert_count++;
        if (b0.prediction !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL sat_floor_pred: got %b expected 0", b0.prediction);
        end
    endtask

    // Index 0 is at 1; same-cycle request reads the old value.
    task automatic test_back_to_back();
        pulse0(1'b1, 32'h40, 1'b1, 4'd0, 1'b1);
        assert_count++;
        if (b0.prediction !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL same_cycle_pred: got %b expected 0", b0.prediction);
        end
        pulse0(1'b1, 32'h40, 1'b0, 4'd0, 1'b0);
        assert_count++;
        if (b0.prediction !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL after_update_pred: got %b expected 1", b0.prediction);
        end
        assert_count++;
        if (b0.stat_updates !== 16'd9 || b0.stat_mispredicts !== 16'd5) begin
            fail_count++;
            $display("[TB] FAIL same_cycle_stats: got %0d/%0d expected 9/5",
                     b0.stat_updates, b0.stat_mispredicts);
        end
    endtask

    // Index 0 trained to 3 through pc 0x40; 0x80 aliases, 0x44 does not.
    task automatic test_aliasing();
        pulse0(1'b0, 32'h40, 1'b1, 4'd0, 1'b1);
        pulse0(1'b1, 32'h80, 1'b0, 4'd0, 1'b0);
        assert_count++;
        if (b0.prediction_index !== 4'd0 || b0.prediction !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL alias_80: got idx=%0d pred=%b expected idx=0 pred=1",
                     b0.prediction_index, b0.prediction);
        end
        pulse0(1'b1, 32'h44, 1'b0, 4'd0, 1'b0);
        assert_count++;
        if (b0.prediction_index !== 4'd1 || b0.prediction !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL alias_44: got idx=%0d pred=%b expected idx=1 pred=0",
                     b0.prediction_index, b0.prediction);
        end
        // Index holds while idle.
        step();
        assert_count++;
        if (b0.prediction_index !== 4'd1 || b0.prediction_valid !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL hold_index: got idx=%0d valid=%b expected idx=1 valid=0",
                     b0.prediction_index, b0.prediction_valid);
        end
    endtask

    task automatic test_gshare();
        pulse1(1'b0, 32'h0, 1'b1, 4'd0, 1'b1);
        pulse1(1'b0, 32'h0, 1'b1, 4'd0, 1'b1);
        // ghr = 0011; pc 0x14 -> 5 ^ 3 = 6, same-cycle result uses old ghr.
        pulse1(1'b1, 32'h14, 1'b1, 4'd2, 1'b0);
        assert_count++;
        if (b1.prediction_index !== 4'd6 || b1.prediction !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL gshare_idx6: got idx=%0d pred=%b expected idx=6 pred=0",
                     b1.prediction_index, b1.prediction);
        end
        // ghr = 0110; 5 ^ 6 = 3.
        pulse1(1'b1, 32'h14, 1'b0, 4'd0, 1'b0);
        assert_count++;
        if (b1.prediction_index !== 4'd3) begin
            fail_count++;
            $display("[TB] FAIL gshare_idx3: got %0d expected 3", b1.prediction_index);
        end
        assert_count++;
        if (b1.stat_updates !== 2'd3 || b1.stat_mispredicts !== 2'd1) begin
            fail_count++;
            $display("[TB] FAIL gshare_stats: got %0d/%0d expected 3/1",
                     b1.stat_updates, b1.stat_mispredicts);
        end
        // Three more mispredict-ish updates: updates stay at 3, mispredicts 2,3,3.
        pulse1(1'b0, 32'h0, 1'b1, 4'd5, 1'b1);
        pulse1(1'b0, 32'h0, 1'b1, 4'd7, 1'b1);
        pulse1(1'b0, 32'h0, 1'b1, 4'd8, 1'b1);
        assert_count++;
        if (b1.stat_updates !== 2'd3 || b1.stat_mispredicts !== 2'd3) begin
            fail_count++;
            $display("[TB] FAIL stat_saturate: got %0d/%0d expected 3/3",
                     b1.stat_updates, b1.stat_mispredicts);
        end
    endtask

    task automatic test_reset_mid_burst();
        // Index 1 goes 1->2->3 while requests stream.
        b0.request      = 1'b1;
        b0.request_pc   = 32'h40;
        b0.result       = 1'b1;
        b0.result_index = 4'd1;
        b0.taken        = 1'b1;
        step();
        step();
        b0.result     = 1'b0;
        b0.request_pc = 32'h44;
        step();
        assert_count++;
        if (b0.prediction !== 1'b1 || b0.prediction_index !== 4'd1 ||
            b0.stat_updates !== 16'd12) begin
            fail_count++;
            $display("[TB] FAIL burst_state: got pred=%b idx=%0d upd=%0d expected 1/1/12",
                     b0.prediction, b0.prediction_index, b0.stat_updates);
        end
        #2;
        reset = 1'b1;
        #1;
        assert_count++;
        if (b0.prediction !== 1'b0 || b0.prediction_valid !== 1'b0 ||
            b0.prediction_index !== 4'd0) begin
            fail_count++;
            $display("[TB] FAIL async_reset_outputs: got pred=%b valid=%b idx=%0d expected 0/0/0",
                     b0.prediction, b0.prediction_valid, b0.prediction_index);
        end
        assert_count++;
        if (b0.stat_updates !== 16'd0 || b0.stat_mispredicts !== 16'd0) begin
            fail_count++;
            $display("[TB] FAIL async_reset_stats: got %0d/%0d expected 0/0",
                     b0.stat_updates, b0.stat_mispredicts);
        end
        step();
        b0.request = 1'b0;
        reset      = 1'b0;
        pulse0(1'b1, 32'h44, 1'b0, 4'd0, 1'b0);
        assert_count++;
        if (b0.prediction !== 1'b0 || b0.prediction_valid !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL post_reset_idx1: got pred=%b valid=%b expected 0/1",
                     b0.prediction, b0.prediction_valid);
        end
        pulse0(1'b1, 32'h40, 1'b0, 4'd0, 1'b0);
        assert_count++;
        if (b0.prediction !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL post_reset_idx0: got %b expected 0", b0.prediction);
        end
    endtask

    // Hard time bound so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        b0.request = 1'b0; b0.request_pc = '0; b0.result = 1'b0;
        b0.result_index = '0; b0.taken = 1'b0;
        b1.request = 1'b0; b1.request_pc = '0; b1.result = 1'b0;
        b1.result_index = '0; b1.taken = 1'b0;

        test_reset();
        test_first_request();
        test_saturation();
        test_back_to_back();
        test_aliasing();
        test_gshare();
        test_reset_mid_burst();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end
endmodule
